// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller wrapped around an external 1-bit full adder.
// One bit pair per cycle, LSB first, with a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  // Handshake: start is sampled only while busy=0 (IDLE or DONE); an edge with
  // start=1 there is the accept edge. done pulses for one cycle, and sum/cout
  // stay valid from done until the next accept edge.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, last;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no slice.
  always_comb begin
    sum_next            = sum >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        carry <= cin;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state == SHIFT) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        cnt   <= cnt + CW'(1);
        sum   <= sum_next;
        if (last) cout <= fa_co;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign fa_a = busy & a_sh[0];
  assign fa_b = busy & b_sh[0];
  assign fa_c = busy & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 instance for vectors, corner sequences and
// random adds, plus a WIDTH=2 instance swept exhaustively.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] a_in, b_in, sum;
  logic       fa_a, fa_b, fa_c, fa_s, fa_co, cout, busy, done;

  logic       start2, cin2;
  logic [1:0] a2, b2, sum2;
  logic       fa_a2, fa_b2, fa_c2, fa_s2, fa_co2, cout2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Full adder cells wired to each controller.
  assign fa_s   = fa_a ^ fa_b ^ fa_c;
  assign fa_co  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  assign fa_s2  = fa_a2 ^ fa_b2 ^ fa_c2;
  assign fa_co2 = (fa_a2 & fa_b2) | (fa_a2 & fa_c2) | (fa_b2 & fa_c2);

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_co(fa_co),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
    .fa_a(fa_a2), .fa_b(fa_b2), .fa_c(fa_c2), .fa_s(fa_s2), .fa_co(fa_co2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Carry into bit k of a+b+c, from plain arithmetic on the operands.
  function automatic int carry_into(input int a, input int b, input int c, input int k);
    int mask;
    mask = (1 << k) - 1;
    return ((a & mask) + (b & mask) + c) >> k;
  endfunction

  // One add on the WIDTH=8 instance. Returns at the negedge of the done cycle.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co,
                        output int nbusy, output int lat);
    bit got;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; lat = 0; got = 0; s = 'x; co = 1'bx;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (done) begin
        got = 1; lat = i; s = sum; co = cout;
      end else begin
        if (busy) begin
          check("fa_a", {31'd0, fa_a}, (int'(a) >> nbusy) & 1);
          check("fa_b", {31'd0, fa_b}, (int'(b) >> nbusy) & 1);
          check("fa_c", {31'd0, fa_c}, carry_into(a, b, c, nbusy) & 1);
          nbusy++;
        end
        @(negedge clk);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_add2(input logic [1:0] a, input logic [1:0] b, input logic c);
    bit got;
    int k;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    got = 0; k = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      if (done2) begin
        got = 1;
        check("w2_lat", i, 3);
        check("w2_result", {29'd0, cout2, sum2}, int'(a) + int'(b) + int'(c));
      end else begin
        if (busy2) begin
          check("w2_fa_c", {31'd0, fa_c2}, carry_into(a, b, c, k) & 1);
          k++;
        end
        @(negedge clk);
      end
    end
    if (!got) check("w2_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] s, ra, rb;
    logic       co, rc;
    int nb, lat, ndone, t;
    bit second_busy, seen;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_c}, 0);
    check("rst_w2", {28'd0, busy2, done2, sum2}, 0);
    rst = 1'b0; start = 1'b0; start2 = 1'b0;

    // Table vectors
    foreach (vecs[i]) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].c, s, co, nb, lat);
      check("vec_sum", {24'd0, s}, {24'd0, vecs[i].exp_sum});
      check("vec_cout", {31'd0, co}, {31'd0, vecs[i].exp_cout});
      check("vec_busy_cycles", nb, 8);
      check("vec_done_latency", lat, 9);
      @(negedge clk);
      check("vec_done_pulse", {31'd0, done}, 0);
    end

    // start pulsed mid-shift is ignored
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; second_busy = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++; seen = 1;
        check("ign_sum", {24'd0, sum}, 32'h46);
      end else if (seen && busy) second_busy = 1;
      @(negedge clk);
    end
    check("ign_done_count", ndone, 1);
    check("ign_no_rebusy", {31'd0, second_busy}, 0);

    // Reset mid-shift aborts
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    check("abort_fa", {29'd0, fa_a, fa_b, fa_c}, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    do_add(8'h0F, 8'h01, 1'b0, s, co, nb, lat);
    check("post_abort_sum", {23'd0, co, s}, 32'h010);

    // Back-to-back: start held through DONE
    @(negedge clk);
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h02; cin = 1'b0; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b_first_done", {31'd0, seen}, 1);
    check("b2b_first_sum", {23'd0, cout, sum}, 32'h003);
    a_in = 8'h80; b_in = 8'h80;
    t = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 1);
      end
      if (done) seen = 1;
    end
    check("b2b_spacing", t, 9);
    check("b2b_second_sum", {23'd0, cout, sum}, 32'h100);

    // Random adds against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      do_add(ra, rb, rc, s, co, nb, lat);
      check("rnd_result", {23'd0, co, s}, int'(ra) + int'(rb) + int'(rc));
      check("rnd_latency", lat, 9);
    end

    // Exhaustive WIDTH=2
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          do_add2(2'(a), 2'(b), 1'(c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
